serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes SLICE bits per clock through a registered carry. It is the sequential, width-generic successor to the combinational full-adder cell and serves as the arithmetic primitive for area-constrained datapaths. It uses a start/busy/done handshake, so a controller can issue one operation at a time and collect a held result.

---
 rtl/serial_adder.sv | 141 ++++++++++++++
 tb/tb_serial_adder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Multi-cycle adder/subtractor processing SLICE bits per clock
//            through a registered carry, with a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cy
);

    localparam int c_n_slices = WIDTH / SLICE;
    localparam int c_cnt_w    = (c_n_slices > 1) ? $clog2(c_n_slices) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_n_slices - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               carry_q, carry_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cy_q, cy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SLICE:0]     w_sum;
    logic [WIDTH-1:0]   w_res_shift;

    // One SLICE-bit ripple: low slices of the operand registers plus carry
    assign w_sum = {1'b0, a_sh_q[SLICE-1:0]} + {1'b0, b_sh_q[SLICE-1:0]}
                 + {{SLICE{1'b0}}, carry_q};

    // New slice enters at the MSB end; a full-width slice replaces the result
    generate
        if (SLICE == WIDTH) begin : g_res_full
            assign w_res_shift = w_sum[SLICE-1:0];
        end else begin : g_res_shift
            assign w_res_shift = {w_sum[SLICE-1:0], res_q[WIDTH-1:SLICE]};
        end
    endgenerate

    // Next-state logic: accept in IDLE, one slice per cycle in ADD
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        s_d     = s_q;
        cy_d    = cy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    // Subtract is a + ~b + 1; the carry-in is forced to 1
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : c;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_sh_d  = a_sh_q >> SLICE;
                b_sh_d  = b_sh_q >> SLICE;
                carry_d = w_sum[SLICE];
                res_d   = w_res_shift;
                cnt_d   = cnt_q + c_cnt_one;
                if (cnt_q == c_cnt_last) begin
                    s_d     = w_res_shift;
                    cy_d    = w_sum[SLICE];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cy_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cy_q    <= cy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cy   = cy_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Scoreboard bench for serial_adder over six WIDTH/SLICE configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    // Config g: 0..2 are WIDTH=8 with SLICE 1,4,2; 3..5 are WIDTH=4 with SLICE 1,2,4
    function automatic int w_of(input int g);
        return (g < 3) ? 8 : 4;
    endfunction

    function automatic int s_of(input int g);
        case (g)
            0: return 1;
            1: return 4;
            2: return 2;
            3: return 1;
            4: return 2;
            default: return 4;
        endcase
    endfunction

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       start_v;
    logic [7:0]       a_in, b_in;
    logic             c_in, sub_in;
    logic [5:0]       busy_o, done_o, cy_o;
    logic [5:0][7:0]  s_o;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int busy_run [6];
    int done_cnt [6];

    typedef struct {
        int         g;
        logic [7:0] s;
        logic       cy;
        int         acc;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < 6; g++) begin : g_dut
            localparam int W = w_of(g);
            localparam int S = s_of(g);
            logic [W-1:0] s_w;
            serial_adder #(.WIDTH(W), .SLICE(S)) u_dut (
                .clk   (clk),
                .rst   (rst),
                .start (start_v[g]),
                .a     (a_in[W-1:0]),
                .b     (b_in[W-1:0]),
                .c     (c_in),
                .sub   (sub_in),
                .busy  (busy_o[g]),
                .done  (done_o[g]),
                .s     (s_w),
                .cy    (cy_o[g])
            );
            assign s_o[g] = 8'(s_w);
        end
    endgenerate

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain unsigned arithmetic modulo 2^WIDTH
    function automatic void ref_model(input int g, input logic [7:0] a, input logic [7:0] b,
                                      input logic c, input logic sub,
                                      output logic [7:0] s, output logic cy);
        int w, m, ai, bi, t;
        w  = w_of(g);
        m  = (1 << w) - 1;
        ai = int'(a) & m;
        bi = int'(b) & m;
        if (sub) begin
            t  = (ai - bi) & m;
            s  = 8'(t);
            cy = (ai >= bi);
        end else begin
            t  = ai + bi + int'(c);
            s  = 8'(t & m);
            cy = ((t >> w) & 1) == 1;
        end
    endfunction

    // Drive a one-cycle start, push the expectation, then scramble operands
    task automatic issue(input int g, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic sub);
        exp_t e;
        logic [7:0] es;
        logic ec;
        a_in = a; b_in = b; c_in = c; sub_in = sub;
        start_v[g] = 1'b1;
        @(posedge clk);
        #1;
        start_v[g] = 1'b0;
        ref_model(g, a, b, c, sub, es, ec);
        e.g = g; e.s = es; e.cy = ec; e.acc = cyc;
        q.push_back(e);
        a_in = 8'($urandom); b_in = 8'($urandom);
        c_in = 1'($urandom); sub_in = 1'($urandom);
    endtask

    // Returns at the negedge of the done cycle (bounded)
    task automatic wait_done(input int g);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (done_o[g]) seen = 1'b1;
        end
        chk("done_timeout", seen, 0, 1);
    endtask

    // Monitor: pops the scoreboard whenever a DUT raises done
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 6; g++) begin
            if (rst) busy_run[g] = 0;
            else if (busy_o[g]) busy_run[g]++;
            if (done_o[g] && !rst) begin
                done_cnt[g]++;
                if (q.size() == 0 || q[0].g != g) begin
                    chk("unexpected_done", q.size() > 0 && q[0].g == g, g, -1);
                end else begin
                    e = q.pop_front();
                    chk("sum", s_o[g] == e.s, s_o[g], e.s);
                    chk("carry", cy_o[g] == e.cy, cy_o[g], e.cy);
                    chk("latency", (cyc - e.acc) == w_of(g) / s_of(g), cyc - e.acc, w_of(g) / s_of(g));
                    chk("busy_cycles", busy_run[g] == w_of(g) / s_of(g), busy_run[g], w_of(g) / s_of(g));
                end
                busy_run[g] = 0;
            end
        end
    end

    initial begin
        int dc;
        for (int g = 0; g < 6; g++) begin
            busy_run[g] = 0;
            done_cnt[g] = 0;
        end
        rst = 1'b1; start_v = '0; a_in = '0; b_in = '0; c_in = 1'b0; sub_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state of every configuration
        for (int g = 0; g < 6; g++) begin
            chk("rst_busy", busy_o[g] == 1'b0, busy_o[g], 0);
            chk("rst_done", done_o[g] == 1'b0, done_o[g], 0);
            chk("rst_s", s_o[g] == 8'h00, s_o[g], 0);
            chk("rst_cy", cy_o[g] == 1'b0, cy_o[g], 0);
        end

        // Plain add, SLICE=1
        issue(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_done(0);

        // Carry wrap then back-to-back in the done cycle, SLICE=4
        issue(1, 8'hFF, 8'h00, 1'b1, 1'b0);
        wait_done(1);
        issue(1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_done(1);

        // Subtract, SLICE=2 (carry-in ignored), with and without borrow
        @(negedge clk);
        issue(2, 8'h10, 8'h01, 1'b1, 1'b1);
        wait_done(2);
        @(negedge clk);
        issue(2, 8'h01, 8'h02, 1'b0, 1'b1);
        wait_done(2);

        // Start while busy is ignored
        @(negedge clk);
        dc = done_cnt[0];
        issue(0, 8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a_in = 8'h80; b_in = 8'h80; start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        wait_done(0);
        repeat (12) @(negedge clk);
        chk("busy_start_dones", done_cnt[0] - dc == 1, done_cnt[0] - dc, 1);

        // Reset mid-operation aborts with no done and clears the result
        dc = done_cnt[0];
        issue(0, 8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        chk("abort_busy", busy_o[0] == 1'b0, busy_o[0], 0);
        chk("abort_done", done_o[0] == 1'b0, done_o[0], 0);
        chk("abort_s", s_o[0] == 8'h00, s_o[0], 0);
        chk("abort_cy", cy_o[0] == 1'b0, cy_o[0], 0);
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt[0] == dc, done_cnt[0] - dc, 0);
        issue(0, 8'h03, 8'h04, 1'b0, 1'b0);
        wait_done(0);

        // Randomized operations on the 8-bit configurations
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 60; k++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                issue(g, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
                wait_done(g);
            end
        end

        // Exhaustive sweep on the 4-bit configurations
        for (int g = 3; g < 6; g++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    for (int m = 0; m < 4; m++) begin
                        issue(g, 8'(a), 8'(b), m[0], m[1]);
                        wait_done(g);
                    end
                end
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size() == 0, q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
